// File: rtl/mux_pc_reg_if.sv
// Bundle of next-PC sources, control requests and PC status outputs for mux_pc_reg.
interface mux_pc_reg_if #(
  parameter int WIDTH = 32,
  parameter int NSRC  = 4,
  parameter int SEL_W = 2
);
  logic [SEL_W-1:0]      selector;
  logic [NSRC*WIDTH-1:0] data_in;
  logic                  pc_write;
  logic                  exc_req;
  logic                  halt_req;
  logic                  resume;
  logic [WIDTH-1:0]      pc;
  logic [WIDTH-1:0]      pc_plus4;
  logic [WIDTH-1:0]      epc;
  logic                  misalign;
  logic                  halted;

  modport master (
    output selector, data_in, pc_write, exc_req, halt_req, resume,
    input  pc, pc_plus4, epc, misalign, halted
  );

  modport slave (
    input  selector, data_in, pc_write, exc_req, halt_req, resume,
    output pc, pc_plus4, epc, misalign, halted
  );
endinterface

// File: rtl/mux_pc_reg.sv
// Program counter register with a multiplexed next-PC source, exception and
// misalignment redirect, and a BOOT/RUN/HALTED control FSM.
module mux_pc_reg #(
  parameter int               WIDTH        = 32,
  parameter int               NSRC         = 4,
  parameter int               SEL_W        = 2,
  parameter logic [WIDTH-1:0] RESET_VECTOR = WIDTH'(32'h0000_0000),
  parameter logic [WIDTH-1:0] EXC_VECTOR   = WIDTH'(32'h0000_0080)
) (
  input logic          clk,
  input logic          reset_n,
  mux_pc_reg_if.slave  bus
);

  localparam logic [1:0] S_BOOT   = 2'd0;
  localparam logic [1:0] S_RUN    = 2'd1;
  localparam logic [1:0] S_HALTED = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] pc_q, pc_d;
  logic [WIDTH-1:0] epc_q, epc_d;
  logic             misalign_q, misalign_d;
  logic [WIDTH-1:0] candidate;

  // Out-of-range selector values fall back to source 0.
  always_comb begin
    candidate = bus.data_in[WIDTH-1:0];
    for (int k = 1; k < NSRC; k++) begin
      if (bus.selector == SEL_W'(k)) begin
        candidate = bus.data_in[k*WIDTH +: WIDTH];
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    epc_d      = epc_q;
    misalign_d = 1'b0;
    case (state_q)
      S_BOOT: begin
        state_d = S_RUN;
      end
      S_RUN: begin
        if (bus.exc_req) begin
          pc_d  = EXC_VECTOR;
          epc_d = pc_q;
        end else if (bus.pc_write && (candidate[1:0] != 2'b00)) begin
          pc_d       = EXC_VECTOR;
          epc_d      = candidate;
          misalign_d = 1'b1;
        end else if (bus.halt_req) begin
          state_d = S_HALTED;
        end else if (bus.pc_write) begin
          pc_d = candidate;
        end
      end
      S_HALTED: begin
        // An exception wakes the core; resume beats a simultaneous halt_req.
        if (bus.exc_req) begin
          state_d = S_RUN;
          pc_d    = EXC_VECTOR;
          epc_d   = pc_q;
        end else if (bus.resume) begin
          state_d = S_RUN;
        end
      end
      default: begin
        state_d = S_BOOT;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_BOOT;
      pc_q       <= RESET_VECTOR;
      epc_q      <= '0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      epc_q      <= epc_d;
      misalign_q <= misalign_d;
    end
  end

  assign bus.pc       = pc_q;
  assign bus.pc_plus4 = pc_q + WIDTH'(4);
  assign bus.epc      = epc_q;
  assign bus.misalign = misalign_q;
  assign bus.halted   = (state_q == S_HALTED);

endmodule

// File: tb/tb_mux_pc_reg.sv
// Scoreboard bench for mux_pc_reg: directed steps push expected PC state into a
// queue, and a monitor compares it against the DUT away from the clock edge.
module tb_mux_pc_reg;

  logic clk     = 1'b0;
  logic reset_n = 1'b0;

  always #5 clk = ~clk;

  mux_pc_reg_if #(.WIDTH(32), .NSRC(4), .SEL_W(2)) bus0 ();
  mux_pc_reg_if #(.WIDTH(32), .NSRC(3), .SEL_W(2)) bus1 ();

  mux_pc_reg #(
    .WIDTH(32), .NSRC(4), .SEL_W(2),
    .RESET_VECTOR(32'h0000_0000), .EXC_VECTOR(32'h0000_0080)
  ) dut0 (
    .clk(clk), .reset_n(reset_n), .bus(bus0)
  );

  mux_pc_reg #(
    .WIDTH(32), .NSRC(3), .SEL_W(2),
    .RESET_VECTOR(32'h0000_0000), .EXC_VECTOR(32'h0000_0080)
  ) dut1 (
    .clk(clk), .reset_n(reset_n), .bus(bus1)
  );

  typedef struct {
    int          id;
    string       name;
    logic [31:0] pc;
    logic [31:0] epc;
    logic        mis;
    logic        halt;
  } exp_t;

  exp_t sb_q[$];
  int   total = 0;
  int   bad   = 0;
  event sample_ev;

  task automatic compareField(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s got=%h exp=%h", name, act, exp);
    end
  endtask

  task automatic checkOutput(exp_t e);
    logic [31:0] a_pc, a_p4, a_epc;
    logic        a_mis, a_halt;
    if (e.id == 0) begin
      a_pc = bus0.pc; a_p4 = bus0.pc_plus4; a_epc = bus0.epc;
      a_mis = bus0.misalign; a_halt = bus0.halted;
    end else begin
      a_pc = bus1.pc; a_p4 = bus1.pc_plus4; a_epc = bus1.epc;
      a_mis = bus1.misalign; a_halt = bus1.halted;
    end
    compareField({e.name, ".pc"}, a_pc, e.pc);
    compareField({e.name, ".pc_plus4"}, a_p4, e.pc + 32'd4);
    compareField({e.name, ".epc"}, a_epc, e.epc);
    compareField({e.name, ".misalign"}, {31'd0, a_mis}, {31'd0, e.mis});
    compareField({e.name, ".halted"}, {31'd0, a_halt}, {31'd0, e.halt});
  endtask

  // Monitor: drains the scoreboard at each falling edge, or on demand for async checks.
  initial begin
    forever begin
      @(negedge clk or sample_ev);
      while (sb_q.size() > 0) checkOutput(sb_q.pop_front());
    end
  end

  task automatic expectOutput(int id, string name, logic [31:0] pc, logic [31:0] epc,
                              logic mis, logic halt);
    exp_t e;
    e.id = id; e.name = name; e.pc = pc; e.epc = epc; e.mis = mis; e.halt = halt;
    sb_q.push_back(e);
  endtask

  task automatic applyStimulus(logic [1:0] sel, logic pw, logic exc, logic hr, logic rs);
    bus0.selector = sel;
    bus0.pc_write = pw;
    bus0.exc_req  = exc;
    bus0.halt_req = hr;
    bus0.resume   = rs;
  endtask

  task automatic setSrc(int k, logic [31:0] v);
    bus0.data_in[k*32 +: 32] = v;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog got=timeout exp=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bus0.data_in = '0;
    setSrc(0, 32'h0000_0100);
    setSrc(1, 32'h0000_0202);
    setSrc(2, 32'h0000_0040);
    setSrc(3, 32'h0000_0200);
    applyStimulus(2'd2, 1'b1, 1'b0, 1'b0, 1'b0);
    bus1.data_in  = {32'h0000_0030, 32'h0000_0020, 32'h0000_0010};
    bus1.selector = 2'd3;
    bus1.pc_write = 1'b1;
    bus1.exc_req  = 1'b0;
    bus1.halt_req = 1'b0;
    bus1.resume   = 1'b0;

    #3;
    expectOutput(0, "in_reset", 32'h0, 32'h0, 1'b0, 1'b0);
    -> sample_ev;

    repeat (2) @(negedge clk);
    #2 reset_n = 1'b1;

    tick();
    expectOutput(0, "boot", 32'h0, 32'h0, 1'b0, 1'b0);
    expectOutput(1, "n3_boot", 32'h0, 32'h0, 1'b0, 1'b0);
    tick();
    expectOutput(0, "first_load", 32'h40, 32'h0, 1'b0, 1'b0);
    expectOutput(1, "n3_sel3_src0", 32'h10, 32'h0, 1'b0, 1'b0);

    applyStimulus(2'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    bus1.selector = 2'd2;
    tick();
    expectOutput(0, "load_src0", 32'h100, 32'h0, 1'b0, 1'b0);
    expectOutput(1, "n3_sel2", 32'h30, 32'h0, 1'b0, 1'b0);

    applyStimulus(2'd1, 1'b1, 1'b0, 1'b0, 1'b0);
    bus1.selector = 2'd3;
    tick();
    expectOutput(0, "misalign", 32'h80, 32'h202, 1'b1, 1'b0);
    expectOutput(1, "n3_sel3_again", 32'h10, 32'h0, 1'b0, 1'b0);

    applyStimulus(2'd1, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    expectOutput(0, "stall", 32'h80, 32'h202, 1'b0, 1'b0);

    applyStimulus(2'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    expectOutput(0, "reload", 32'h100, 32'h202, 1'b0, 1'b0);

    applyStimulus(2'd1, 1'b1, 1'b1, 1'b0, 1'b0);
    tick();
    expectOutput(0, "exc_over_mis", 32'h80, 32'h100, 1'b0, 1'b0);

    applyStimulus(2'd3, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    expectOutput(0, "load_src3", 32'h200, 32'h100, 1'b0, 1'b0);

    applyStimulus(2'd0, 1'b1, 1'b0, 1'b1, 1'b0);
    tick();
    expectOutput(0, "halt_enter", 32'h200, 32'h100, 1'b0, 1'b1);

    for (int i = 0; i < 10; i++) begin
      applyStimulus(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 1'b0,
                    1'($urandom_range(0, 1)), 1'b0);
      tick();
      expectOutput(0, "halt_hold", 32'h200, 32'h100, 1'b0, 1'b1);
    end

    applyStimulus(2'd0, 1'b1, 1'b0, 1'b1, 1'b1);
    tick();
    expectOutput(0, "resume_wins", 32'h200, 32'h100, 1'b0, 1'b0);

    applyStimulus(2'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    expectOutput(0, "post_resume", 32'h100, 32'h100, 1'b0, 1'b0);

    applyStimulus(2'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    tick();
    expectOutput(0, "resume_in_run", 32'h100, 32'h100, 1'b0, 1'b0);

    applyStimulus(2'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    tick();
    expectOutput(0, "halt_again", 32'h100, 32'h100, 1'b0, 1'b1);

    applyStimulus(2'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    tick();
    expectOutput(0, "exc_wake", 32'h80, 32'h100, 1'b0, 1'b0);

    setSrc(3, 32'hFFFF_FFFC);
    applyStimulus(2'd3, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    expectOutput(0, "wrap", 32'hFFFF_FFFC, 32'h100, 1'b0, 1'b0);

    setSrc(3, 32'h0000_0200);
    tick();
    expectOutput(0, "to_200", 32'h200, 32'h100, 1'b0, 1'b0);

    applyStimulus(2'd0, 1'b1, 1'b0, 1'b1, 1'b0);
    tick();
    expectOutput(0, "halt_before_rst", 32'h200, 32'h100, 1'b0, 1'b1);

    // Pulse reset mid-cycle and check outputs before the next rising edge.
    applyStimulus(2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #3 reset_n = 1'b0;
    #1;
    expectOutput(0, "async_rst", 32'h0, 32'h0, 1'b0, 1'b0);
    -> sample_ev;

    @(negedge clk);
    #2 reset_n = 1'b1;
    applyStimulus(2'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    expectOutput(0, "boot_after_rst", 32'h0, 32'h0, 1'b0, 1'b0);
    tick();
    expectOutput(0, "load_after_rst", 32'h100, 32'h0, 1'b0, 1'b0);

    for (int i = 0; i < 4; i++) begin
      if (sb_q.size() == 0) break;
      @(negedge clk);
      #1;
    end
    if (sb_q.size() != 0) begin
      total++;
      bad++;
      $display("[TB] FAIL drain got=%0d exp=0", sb_q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mux_pc_reg.md
MUX_PC_REG -- requirements
Module: mux_pc_reg

Interface
REQ-001 Parameter WIDTH, default 32, width of the PC and of every source word.
REQ-002 Parameter NSRC, default 4, number of next-PC sources (2..16).
REQ-003 Parameter SEL_W, default 2, selector width (>= clog2(NSRC)).
REQ-004 Parameter RESET_VECTOR, default 32'h0000_0000, PC value loaded by reset.
REQ-005 Parameter EXC_VECTOR, default 32'h0000_0080, exception/misalign target.
REQ-006 clk  input  1  single clock; all state on rising edge.
REQ-007 reset_n  input  1  reset, asynchronous assert, active-low.
REQ-008 selector  input  SEL_W  index of the source loaded as next PC.
REQ-009 data_in  input  NSRC*WIDTH  flattened sources; source k = data_in[k*WIDTH +: WIDTH].
REQ-010 pc_write  input  1  load enable; 0 = stall, PC holds.
REQ-011 exc_req  input  1  external exception request.
REQ-012 halt_req  input  1  enter HALTED.
REQ-013 resume  input  1  leave HALTED.
REQ-014 pc  output  WIDTH  current PC (registered).
REQ-015 pc_plus4  output  WIDTH  pc + 4, modulo 2^WIDTH (combinational from pc).
REQ-016 epc  output  WIDTH  PC saved on last exception/misalign (registered).
REQ-017 misalign  output  1  registered one-cycle pulse: rejected unaligned target.
REQ-018 halted  output  1  1 while in HALTED.

Function
REQ-019 FSM states BOOT, RUN, HALTED; reset enters BOOT.
REQ-020 BOOT: PC holds RESET_VECTOR for exactly one cycle, ignores all inputs, then RUN.
REQ-021 RUN: next-PC candidate = source[selector]; selector >= NSRC selects source 0.
REQ-022 RUN update priority per edge: exc_req > misalign > halt_req > pc_write > hold.
REQ-023 exc_req=1 in RUN: pc <= EXC_VECTOR, epc <= pc, regardless of pc_write; misalign stays 0.
REQ-024 Misalign: pc_write=1, exc_req=0, candidate[1:0]!=0 -> pc <= EXC_VECTOR, epc <= candidate, misalign=1 next cycle only.
REQ-025 Aligned candidate, pc_write=1, no higher priority -> pc <= candidate one edge later (latency 1).
REQ-026 pc_write=0, no exc_req -> pc, epc unchanged.
REQ-027 halt_req=1 (no exc_req, no misalign) in RUN -> HALTED next edge; pc not updated that edge even if pc_write=1.
REQ-028 HALTED: pc, epc frozen; pc_write, selector, halt_req ignored; halted=1.
REQ-029 HALTED + exc_req=1 -> RUN, pc <= EXC_VECTOR, epc <= pc (exception wakes core).
REQ-030 HALTED + resume=1, exc_req=0 -> RUN next edge, pc unchanged; resume ignored outside HALTED.
REQ-031 halt_req and resume both 1 in HALTED -> resume wins (leave HALTED).
REQ-032 pc_plus4 wraps: pc = all-ones-minus-3 gives pc_plus4 = 0.

Reset
REQ-033 reset_n=0 asynchronously forces pc=RESET_VECTOR, epc=0, misalign=0, halted=0, state BOOT, including mid-HALTED or mid-exception.
REQ-034 Deassertion of reset_n takes effect at the next rising clk; first PC load occurs no earlier than the second edge after deassertion.

Verification
REQ-035 Reset then pc_write=1, selector=2, source2=32'h0000_0040 -> pc=0 for BOOT cycle, pc=32'h40 after next edge, pc_plus4=32'h44.
REQ-036 RUN, pc=32'h100, pc_write=1, selector=1, source1=32'h0000_0202 -> pc=32'h80, epc=32'h202, misalign high exactly one cycle.
REQ-037 RUN, pc=32'h100, exc_req=1 and misaligned candidate same cycle -> pc=32'h80, epc=32'h100, misalign stays 0.
REQ-038 halt_req=1 with pc_write=1 at pc=32'h200 -> halted=1, pc stays 32'h200 for 10 cycles of random selector/pc_write; resume=1 -> RUN, next load proceeds.
REQ-039 reset_n pulsed low asynchronously mid-cycle while HALTED with pc=32'h200 -> pc=0, halted=0, epc=0 immediately, before the next clk edge.
REQ-040 NSRC=3, SEL_W=2, selector=3, source0=32'h10 -> pc=32'h10.
